// File: rtl/calc_seq_ctrl.sv
// Sequencing controller for the simple-calculator datapath: one op per
// valid/ready handshake, single-cycle ALU ops and a BITS-cycle shift-add MUL.
module calc_seq_ctrl #(
  parameter int BITS = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            op_valid,
  output logic            op_ready,
  input  logic [2:0]      op_mode,
  input  logic [BITS-1:0] operand,
  output logic [BITS-1:0] accum,
  output logic            res_valid,
  output logic            busy,
  output logic            carry,
  output logic            err
);

  localparam int CW = (BITS > 1) ? $clog2(BITS) : 1;

  typedef enum logic [1:0] {IDLE, EXEC, MUL_RUN} state_t;
  typedef enum logic [2:0] {
    OP_RESET = 3'b000,
    OP_ADD   = 3'b001,
    OP_SUB   = 3'b010,
    OP_MUL   = 3'b011,
    OP_LEAD  = 3'b100,
    OP_ONES  = 3'b101
  } opcode_t;

  state_t            state, state_next;
  logic [2:0]        mode_q;
  logic [BITS-1:0]   operand_q;
  logic [CW-1:0]     step;
  logic [2*BITS-1:0] product, product_next;
  logic [BITS-1:0]   exec_accum;
  logic              exec_carry, exec_err;
  logic [BITS:0]     sum;
  logic [BITS-1:0]   ones, lead;
  logic              transfer, mul_last;

  assign op_ready = (state == IDLE);
  assign busy     = ~op_ready;
  assign transfer = op_valid & op_ready;
  assign mul_last = (step == CW'(BITS - 1));

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (transfer) state_next = (op_mode == OP_MUL) ? MUL_RUN : EXEC;
      EXEC:    state_next = IDLE;
      MUL_RUN: if (mul_last) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Single-cycle ALU results, consumed on the EXEC edge.
  always_comb begin
    sum  = {1'b0, accum} + {1'b0, operand_q};
    ones = '0;
    lead = '0;
    for (int unsigned i = 0; i < BITS; i++) begin
      ones = ones + BITS'(operand_q[i]);
      if (operand_q[i]) lead = BITS'(i + 1);
    end
    exec_accum = accum;
    exec_carry = carry;
    exec_err   = 1'b0;
    case (mode_q)
      OP_RESET: begin
        exec_accum = '0;
        exec_carry = 1'b0;
      end
      OP_ADD: {exec_carry, exec_accum} = sum;
      OP_SUB: begin
        exec_accum = accum - operand_q;
        exec_carry = (operand_q > accum);
      end
      OP_LEAD: begin
        exec_accum = lead;
        exec_carry = 1'b0;
      end
      OP_ONES: begin
        exec_accum = ones;
        exec_carry = 1'b0;
      end
      default: exec_err = 1'b1;
    endcase
    // accum is stable throughout MUL_RUN, so it serves directly as multiplicand.
    product_next = product +
                   (operand_q[step] ? ({{BITS{1'b0}}, accum} << step) : '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      accum     <= '0;
      carry     <= 1'b0;
      err       <= 1'b0;
      res_valid <= 1'b0;
      step      <= '0;
      product   <= '0;
      mode_q    <= '0;
      operand_q <= '0;
    end else begin
      res_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (transfer) begin
            mode_q    <= op_mode;
            operand_q <= operand;
            product   <= '0;
            step      <= '0;
          end
        end
        EXEC: begin
          accum     <= exec_accum;
          carry     <= exec_carry;
          err       <= exec_err;
          res_valid <= 1'b1;
        end
        MUL_RUN: begin
          product <= product_next;
          step    <= step + CW'(1);
          if (mul_last) begin
            accum     <= product_next[BITS-1:0];
            carry     <= |product_next[2*BITS-1:BITS];
            err       <= 1'b0;
            res_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
